// File: rtl/lcd_pkg.sv
// Shared constants and state type for the LCD number formatter.
package lcd_pkg;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam int         LINE_LEN   = 16;
  localparam logic [4:0] LINE0_BASE = 5'd0;
  localparam logic [4:0] LINE1_BASE = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_WRITE, S_DONE} state_e;
endpackage

// File: rtl/lcd_num_formatter_bin2bcd.sv
// Iterative double-dabble: one add-3/shift step per clock, WIDTH steps per conversion.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk_100hz,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);
  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [4:0]          cnt_q, cnt_d;
  logic                run_q, run_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;

    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      mag_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
      mag_d = {mag_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // High during the final shift cycle, so the BCD result is settled the cycle after.
  assign done_o = run_q && (cnt_q == LAST);
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/lcd_num_formatter.sv
// Signed binary to right-aligned decimal ASCII, written into a 2x16 LCD character buffer.
module lcd_num_formatter
  import lcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk_100hz,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             line,
  output logic             busy,
  output logic             done,
  input  logic [4:0]       rd_addr,
  output logic [7:0]       rd_data
);
  localparam logic [3:0] NDIG = 4'(DIGITS);

  state_e              state_q, state_d;
  logic [3:0]          col_q, col_d;
  logic                neg_q, line_q;
  logic [7:0]          mem_q [32];
  logic                accept, conv_done, wr_en;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] bcd;
  logic [3:0]          pos, msd, digit;
  logic [7:0]          ch;
  logic [4:0]          wr_addr;

  assign accept = (state_q == S_IDLE) && start;
  // Two's-complement negate; the most-negative value maps onto 2^(WIDTH-1) unsigned.
  assign mag    = value[WIDTH-1] ? (~value + 1'b1) : value;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_b2b (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .start_i   (accept),
    .bin_i     (mag),
    .done_o    (conv_done),
    .bcd_o     (bcd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CONVERT;
      S_CONVERT: if (conv_done) begin
        state_d = S_WRITE;
        col_d   = '0;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        col_d = col_q + 4'd1;
        if (col_q == 4'd15) state_d = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // pos counts columns from the right edge; msd is the highest nonzero digit (0 when all zero).
  always_comb begin
    pos   = 4'd15 - col_q;
    msd   = '0;
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = 4'(i);
      if (pos == 4'(i)) digit = bcd[4*i +: 4];
    end
    if (pos < NDIG && pos <= msd) ch = ZERO | {4'h0, digit};
    else if (neg_q && pos == msd + 4'd1) ch = MINUS;
    else ch = SPACE;
  end

  assign wr_addr = (line_q ? LINE1_BASE : LINE0_BASE) + {1'b0, col_q};

  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      neg_q   <= 1'b0;
      line_q  <= 1'b0;
      for (int i = 0; i < 32; i++) mem_q[i] <= SPACE;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (accept) begin
        neg_q  <= value[WIDTH-1];
        line_q <= line;
      end
      if (wr_en) mem_q[wr_addr] <= ch;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign rd_data = mem_q[rd_addr];
endmodule

// File: tb/tb_lcd_num_formatter.sv
// Bench for lcd_num_formatter: table vectors, random values vs. a string-based display model, corner sequences.
`timescale 1ns/1ps
module tb_lcd_num_formatter;
  logic        clk_100hz = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        line = 1'b0;
  logic        busy, done;
  logic [4:0]  rd_addr = '0;
  logic [7:0]  rd_data;

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [32];

  lcd_num_formatter dut (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .line      (line),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #50 clk_100hz = ~clk_100hz;

  typedef struct {
    logic [15:0] v;
    logic        ln;
    string       txt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Display model: decimal text of the signed value, right-aligned in the 16-column line.
  function automatic void model_write(input logic [15:0] v, input logic ln);
    logic signed [15:0] sv;
    int n, idx;
    string s;
    sv = v;
    n = sv;
    s = $sformatf("%0d", n);
    for (int c = 0; c < 16; c++) begin
      idx = c - (16 - s.len());
      mdl[(ln ? 16 : 0) + c] = (idx >= 0) ? s[idx] : 8'h20;
    end
  endfunction

  task automatic check_buf(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      #1;
      chk($sformatf("%s addr%0d", tag, a), int'(rd_data), int'(mdl[a]));
    end
  endtask

  // Drives start for one cycle just after an edge, then checks done timing relative to that edge.
  task automatic run_conv(input logic [15:0] v, input logic ln, input string tag);
    int cyc;
    @(posedge clk_100hz); #1;
    start = 1'b1; value = v; line = ln;
    @(posedge clk_100hz); #1;
    start = 1'b0; value = 16'($urandom); line = ~ln;
    chk({tag, " busy rise"}, int'(busy), 1);
    cyc = 1;
    while (!done && cyc < 60) begin
      chk({tag, " no early done"}, int'(done), 0);
      @(posedge clk_100hz); #1;
      cyc++;
    end
    chk({tag, " done latency"}, cyc, 33);
    @(posedge clk_100hz); #1;
    chk({tag, " done fall"}, int'(done), 0);
    chk({tag, " busy fall"}, int'(busy), 0);
    model_write(v, ln);
    check_buf(tag);
  endtask

  vec_t tbl [$];

  initial begin
    int dcount, dtimes [$], cyc;
    string exp_line;
    tbl.push_back('{16'd1234, 1'b0, "1234"});
    tbl.push_back('{16'hFFFF, 1'b1, "-1"});
    tbl.push_back('{16'd0,    1'b1, "0"});
    tbl.push_back('{16'h8000, 1'b0, "-32768"});
    tbl.push_back('{16'h7FFF, 1'b0, "32767"});
    tbl.push_back('{16'hFFF6, 1'b1, "-10"});
    tbl.push_back('{16'd10009, 1'b1, "10009"});

    for (int a = 0; a < 32; a++) mdl[a] = 8'h20;
    repeat (3) @(posedge clk_100hz);
    @(negedge clk_100hz) rst = 1'b0;
    @(posedge clk_100hz); #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    check_buf("reset");

    foreach (tbl[i]) begin
      run_conv(tbl[i].v, tbl[i].ln, $sformatf("vec%0d", i));
      exp_line = "";
      for (int k = 0; k < 16 - tbl[i].txt.len(); k++) exp_line = {exp_line, " "};
      exp_line = {exp_line, tbl[i].txt};
      for (int c = 0; c < 16; c++) begin
        rd_addr = 5'((tbl[i].ln ? 16 : 0) + c);
        #1;
        chk($sformatf("vec%0d text col%0d", i, c), int'(rd_data), int'(exp_line[c]));
      end
    end

    for (int r = 0; r < 12; r++)
      run_conv(16'($urandom), 1'($urandom), $sformatf("rnd%0d", r));

    // start re-asserted mid-conversion and during DONE must be ignored.
    @(posedge clk_100hz); #1;
    start = 1'b1; value = 16'd4321; line = 1'b0;
    dcount = 0;
    cyc = 0;
    for (int i = 1; i <= 120; i++) begin
      @(posedge clk_100hz); #1;
      if (i == 1 || i == 5) start = 1'b0;
      if (i == 4) start = 1'b1;
      if (cyc != 0 && i == cyc + 1) start = 1'b0;
      if (done) begin
        dcount++;
        cyc = i;
        start = 1'b1;
      end
    end
    start = 1'b0;
    chk("ignored start done count", dcount, 1);
    chk("ignored start done time", cyc, 33);
    model_write(16'd4321, 1'b0);
    check_buf("ignored");

    // start held high: back-to-back conversions.
    @(posedge clk_100hz); #1;
    start = 1'b1; value = 16'hFC18; line = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      @(posedge clk_100hz); #1;
      if (done) dtimes.push_back(i);
    end
    start = 1'b0;
    chk("held done pulses", dtimes.size(), 3);
    if (dtimes.size() >= 3) begin
      chk("held first done", dtimes[0], 33);
      chk("held gap1", dtimes[1] - dtimes[0], 34);
      chk("held gap2", dtimes[2] - dtimes[1], 34);
    end
    cyc = 0;
    while (busy && cyc < 60) begin
      @(posedge clk_100hz); #1;
      cyc++;
    end
    chk("held drain", int'(busy), 0);
    model_write(16'hFC18, 1'b1);
    check_buf("held");

    // Asynchronous reset in the middle of WRITE.
    @(posedge clk_100hz); #1;
    start = 1'b1; value = 16'd31337; line = 1'b1;
    @(posedge clk_100hz); #1;
    start = 1'b0;
    repeat (19) @(posedge clk_100hz);
    #1;
    chk("pre-abort busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    for (int a = 0; a < 32; a++) mdl[a] = 8'h20;
    check_buf("abort");
    @(negedge clk_100hz) rst = 1'b0;
    run_conv(16'd7, 1'b0, "post-abort");
    rd_addr = 5'd15;
    #1;
    chk("post-abort addr15", int'(rd_data), 8'h37);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
